// File: rtl/result_logger_if.sv
// result_logger_if: capture inputs, show-ahead drain handshake and status of result_logger.
// out_ts exists only when RESULT_LOGGER_TS_EN is defined.
interface result_logger_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int TS_WIDTH = 16
);
  logic enable;
  logic [DATA_WIDTH-1:0] Result;
  logic out_valid;
  logic out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [$clog2(DEPTH):0] count;
  logic overflow;
  logic [7:0] drop_count;
`ifdef RESULT_LOGGER_TS_EN
  logic [TS_WIDTH-1:0] out_ts;
  modport master (
    input enable, Result, out_ready,
    output out_valid, out_data, out_ts, count, overflow, drop_count
  );
  modport slave (
    output enable, Result, out_ready,
    input out_valid, out_data, out_ts, count, overflow, drop_count
  );
`else
  logic unused_ts_width;
  assign unused_ts_width = ^TS_WIDTH;
  modport master (
    input enable, Result, out_ready,
    output out_valid, out_data, count, overflow, drop_count
  );
  modport slave (
    output enable, Result, out_ready,
    input out_valid, out_data, count, overflow, drop_count
  );
`endif
endinterface

// File: rtl/result_logger.sv
// result_logger: logs changes of the CPU result into a show-ahead FIFO with sticky overflow and drop count.
// Define RESULT_LOGGER_TS_EN to add a free-running timestamp stored with each entry.
module result_logger #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int TS_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  result_logger_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] last_value;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0] cnt;
  logic primed;
  logic overflow;
  logic [7:0] drops;
  logic capture;
  logic pop;
  logic push;
  assign capture = bus.enable && (!primed || bus.Result != last_value);
  assign pop = (cnt != '0) && bus.out_ready;
  // a full FIFO still accepts an event when the head leaves in the same edge
  assign push = capture && (cnt != FULL || pop);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_value <= '0;
      primed <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
      overflow <= 1'b0;
      drops <= '0;
    end else begin
      if (capture) begin
        last_value <= bus.Result;
        primed <= 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (capture && !push) begin
        overflow <= 1'b1;
        drops <= drops + 8'(drops != 8'hff);
      end
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.Result;
  assign bus.out_valid = cnt != '0;
  assign bus.out_data = mem[rd_ptr];
  assign bus.count = cnt;
  assign bus.overflow = overflow;
  assign bus.drop_count = drops;
`ifdef RESULT_LOGGER_TS_EN
  logic [TS_WIDTH-1:0] ts;
  logic [TS_WIDTH-1:0] ts_mem [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) ts <= '0;
    else ts <= ts + 1'b1;
  always_ff @(posedge clk)
    if (push) ts_mem[wr_ptr] <= ts;
  assign bus.out_ts = ts_mem[rd_ptr];
`else
  logic unused_ts_width;
  assign unused_ts_width = ^TS_WIDTH;
`endif
endmodule

// File: tb/tb_result_logger.sv
// tb_result_logger: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_result_logger;
  localparam int DW = 32;
  localparam int DEPTH = 8;
`ifdef RESULT_LOGGER_TS_EN
  localparam int TSW = 4;
`else
  localparam int TSW = 16;
`endif
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  result_logger_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TS_WIDTH(TSW)) bus ();
  result_logger #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] md [$];
  int mt [$];
  logic [DW-1:0] m_last;
  bit m_primed;
  bit m_ovf;
  int m_drop;
  int m_ts;

  task automatic model_clear();
    md.delete();
    mt.delete();
    m_last = '0;
    m_primed = 0;
    m_ovf = 0;
    m_drop = 0;
    m_ts = 0;
  endtask

  // called at a falling edge; returns at the next falling edge
  task automatic cyc(input bit en, input logic [DW-1:0] r, input bit rdy);
    bit ev;
    bit pop;
    bus.enable = en;
    bus.Result = r;
    bus.out_ready = rdy;
    @(posedge clk);
    ev = en && (!m_primed || r != m_last);
    pop = md.size() != 0 && rdy;
    if (ev) begin
      m_last = r;
      m_primed = 1;
    end
    if (pop) begin
      void'(md.pop_front());
      void'(mt.pop_front());
    end
    if (ev && md.size() < DEPTH) begin
      md.push_back(r);
      mt.push_back(m_ts);
    end else if (ev) begin
      m_ovf = 1;
      if (m_drop < 255) m_drop++;
    end
    m_ts = (m_ts + 1) % (1 << TSW);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.enable = 0;
    bus.out_ready = 0;
    rst = 1;
    #2;
    model_clear();
    rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.enable = 1;
    bus.Result = 32'h1234;
    bus.out_ready = 0;
    rst = 1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.count !== '0) begin n_bad++; $display("FAIL reset_count got %0d want 0", bus.count); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
    n_cmp++; if (bus.drop_count !== 8'd0) begin n_bad++; $display("FAIL reset_drop got %0d want 0", bus.drop_count); end
    do_reset();
  endtask

  task automatic test_hold_zero();
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 32'h0, 0);
    n_cmp++; if (bus.count !== 4'd1) begin n_bad++; $display("FAIL hold_zero_count got %0d want 1", bus.count); end
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0) begin n_bad++; $display("FAIL hold_zero_data got %b/%h want 1/0", bus.out_valid, bus.out_data); end
  endtask

  task automatic test_change_detect();
    logic [DW-1:0] seq [4] = '{32'h5, 32'h5, 32'h7, 32'h5};
    logic [DW-1:0] exp [3] = '{32'h5, 32'h7, 32'h5};
    do_reset();
    foreach (seq[i]) cyc(1, seq[i], 0);
    n_cmp++; if (bus.count !== 4'd3) begin n_bad++; $display("FAIL change_count got %0d want 3", bus.count); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp[i]) begin n_bad++; $display("FAIL change_pop%0d got %b/%h want 1/%h", i, bus.out_valid, bus.out_data, exp[i]); end
      cyc(0, 32'h5, 1);
    end
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.count !== '0) begin n_bad++; $display("FAIL change_empty got %b/%0d want 0/0", bus.out_valid, bus.count); end
  endtask

  task automatic test_overflow_and_full_pop();
    do_reset();
    for (int v = 1; v <= 10; v++) cyc(1, DW'(v), 0);
    n_cmp++; if (bus.count !== 4'd8) begin n_bad++; $display("FAIL ovf_count got %0d want 8", bus.count); end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", bus.overflow); end
    n_cmp++; if (bus.drop_count !== 8'd2) begin n_bad++; $display("FAIL ovf_drop got %0d want 2", bus.drop_count); end
    n_cmp++; if (bus.out_data !== 32'd1) begin n_bad++; $display("FAIL ovf_head got %h want 1", bus.out_data); end
    cyc(0, 32'h0, 0);
    n_cmp++; if (bus.out_data !== 32'd1) begin n_bad++; $display("FAIL hold_head got %h want 1", bus.out_data); end
    cyc(1, 32'hAA, 1);
    n_cmp++; if (bus.count !== 4'd8) begin n_bad++; $display("FAIL full_pop_push_count got %0d want 8", bus.count); end
    n_cmp++; if (bus.drop_count !== 8'd2) begin n_bad++; $display("FAIL full_pop_push_drop got %0d want 2", bus.drop_count); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (bus.out_data !== (i == 7 ? 32'hAA : DW'(i + 2))) begin n_bad++; $display("FAIL drain%0d got %h want %h", i, bus.out_data, (i == 7 ? 32'hAA : DW'(i + 2))); end
      cyc(0, 32'h0, 1);
    end
    n_cmp++; if (bus.count !== '0 || bus.overflow !== 1'b1) begin n_bad++; $display("FAIL drained got %0d/%b want 0/1", bus.count, bus.overflow); end
  endtask

  task automatic test_drop_saturate();
    do_reset();
    for (int v = 1; v <= 8; v++) cyc(1, DW'(v), 0);
    for (int i = 0; i < 260; i++) cyc(1, DW'(100 + (i % 2)), 0);
    n_cmp++; if (bus.drop_count !== 8'd255) begin n_bad++; $display("FAIL drop_sat got %0d want 255", bus.drop_count); end
    n_cmp++; if (bus.count !== 4'd8 || bus.out_data !== 32'd1) begin n_bad++; $display("FAIL drop_sat_fifo got %0d/%h want 8/1", bus.count, bus.out_data); end
  endtask

  task automatic test_empty_push_ready();
    do_reset();
    cyc(1, 32'h33, 1);
    n_cmp++; if (bus.count !== 4'd1 || bus.out_data !== 32'h33) begin n_bad++; $display("FAIL empty_push got %0d/%h want 1/33", bus.count, bus.out_data); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int v = 1; v <= 4; v++) cyc(1, DW'(v), 0);
    cyc(1, 32'h4, 0);
    #2;
    rst = 1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.count !== '0 || bus.overflow !== 1'b0 || bus.drop_count !== 8'd0)
      begin n_bad++; $display("FAIL async_reset got %b/%0d/%b/%0d want 0/0/0/0", bus.out_valid, bus.count, bus.overflow, bus.drop_count); end
    rst = 0;
    model_clear();
    @(negedge clk);
    cyc(1, 32'h4, 0);
    n_cmp++; if (bus.count !== 4'd1 || bus.out_data !== 32'h4) begin n_bad++; $display("FAIL post_reset_capture got %0d/%h want 1/4", bus.count, bus.out_data); end
  endtask

`ifdef RESULT_LOGGER_TS_EN
  task automatic test_timestamp();
    int exp [3] = '{3, 10, 4};
    do_reset();
    for (int k = 0; k <= 20; k++) cyc(k == 3 || k == 10 || k == 20, DW'(k + 1), 0);
    n_cmp++; if (bus.count !== 4'd3) begin n_bad++; $display("FAIL ts_count got %0d want 3", bus.count); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.out_ts !== TSW'(exp[i])) begin n_bad++; $display("FAIL ts%0d got %0d want %0d", i, bus.out_ts, exp[i]); end
      cyc(0, 32'h0, 1);
    end
  endtask
`endif

  task automatic test_random();
    bit en;
    bit rdy;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      en = $urandom_range(0, 3) != 0;
      rdy = (i / 250) % 2 == 0 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0;
      cyc(en, DW'($urandom_range(0, 3)), rdy);
      n_cmp++; if (bus.count !== 4'(md.size()) || bus.out_valid !== (md.size() != 0)) begin n_bad++; $display("FAIL rnd_count[%0d] got %0d/%b want %0d", i, bus.count, bus.out_valid, md.size()); end
      n_cmp++; if (bus.overflow !== m_ovf || bus.drop_count !== 8'(m_drop)) begin n_bad++; $display("FAIL rnd_ovf[%0d] got %b/%0d want %b/%0d", i, bus.overflow, bus.drop_count, m_ovf, m_drop); end
      if (md.size() != 0) begin
        n_cmp++; if (bus.out_data !== md[0]) begin n_bad++; $display("FAIL rnd_data[%0d] got %h want %h", i, bus.out_data, md[0]); end
`ifdef RESULT_LOGGER_TS_EN
        n_cmp++; if (bus.out_ts !== TSW'(mt[0])) begin n_bad++; $display("FAIL rnd_ts[%0d] got %0d want %0d", i, bus.out_ts, mt[0]); end
`endif
      end
    end
  endtask

  initial begin
    bus.enable = 0;
    bus.Result = '0;
    bus.out_ready = 0;
    test_reset();
    test_hold_zero();
    test_change_detect();
    test_overflow_and_full_pop();
    test_drop_saturate();
    test_empty_push_ready();
    test_async_reset();
`ifdef RESULT_LOGGER_TS_EN
    test_timestamp();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/result_logger.md
RESULT_LOGGER -- requirements
Module: result_logger

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the monitored CPU result and logged data.
REQ-002 Parameter DEPTH, default 8: FIFO entries; power of two, >= 2.
REQ-003 Parameter TS_WIDTH, default 16: timestamp width; used only with RESULT_LOGGER_TS_EN.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  capture enable; high = monitor Result.
REQ-007 Result  input  DATA_WIDTH  CPU result value driven by the processor top level.
REQ-008 out_valid  output  1  head entry available.
REQ-009 out_ready  input  1  consumer accepts head entry.
REQ-010 out_data  output  DATA_WIDTH  head entry value.
REQ-011 out_ts  output  TS_WIDTH  head entry timestamp; present only with RESULT_LOGGER_TS_EN.
REQ-012 count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 overflow  output  1  sticky flag: at least one event dropped.
REQ-014 drop_count  output  8  saturating count of dropped events.

Function
REQ-015 Capture event: enable high AND (primed low OR Result != last_value), evaluated every rising edge.
REQ-016 On every capture event, last_value <= Result and primed <= 1, whether the event is stored or dropped.
REQ-017 enable low: no events; last_value, primed, FIFO contents retained; draining continues.
REQ-018 Pop: out_valid AND out_ready at a rising edge; head advances by one.
REQ-019 Push: capture event AND (not full OR pop in same cycle); entry written at tail.
REQ-020 Full, event, and pop in same cycle: push and pop both occur; count unchanged; no drop.
REQ-021 Empty, event, and out_ready in same cycle: no pop (out_valid low); push occurs; count becomes 1.
REQ-022 Full, event, no pop: event dropped; overflow <= 1; drop_count increments, saturating at 255.
REQ-023 Show-ahead FIFO: out_valid = (count != 0); out_data/out_ts driven from registered storage at head, no combinational path from Result.
REQ-024 Latency: an event at edge N is visible on out_valid/out_data after edge N.
REQ-025 Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-026 out_data holds its value while out_valid is high and out_ready is low.
REQ-027 When out_valid is low, out_data/out_ts are don't-care; the bench checks them only when valid.

Reset
REQ-028 rst high clears immediately: pointers, count = 0, out_valid = 0, overflow = 0, drop_count = 0, primed = 0, last_value = 0, timestamp counter = 0.
REQ-029 Reset mid-operation discards all stored entries; the first enabled cycle after release captures unconditionally.
REQ-030 Storage array contents are not reset.

Configuration
REQ-031 Macro RESULT_LOGGER_TS_EN defined: a free-running TS_WIDTH counter increments every cycle out of reset and wraps to 0; each pushed entry stores the counter value at its push edge; the out_ts port exists.
REQ-032 RESULT_LOGGER_TS_EN undefined: no timestamp counter, no timestamp storage, no out_ts port; all other behaviour identical.

Verification
REQ-033 Reset release, enable = 1, Result held at 0x0 for 5 cycles -> exactly one entry with out_data = 0x0; count = 1.
REQ-034 Result sequence 0x5, 0x5, 0x7, 0x5, out_ready = 0 -> three entries 0x5, 0x7, 0x5; count = 3; then out_ready = 1 pops in order over 3 cycles.
REQ-035 DEPTH = 8, out_ready = 0, 10 distinct values 1..10 -> entries 1..8 retained; overflow = 1; drop_count = 2; count = 8.
REQ-036 FIFO full, out_ready = 1, new value 0xAA in the same cycle -> count stays 8; head advances; 0xAA appears after 8 further pops.
REQ-037 Four entries stored, rst pulsed asynchronously mid-cycle -> out_valid, count, overflow, and drop_count are 0 before the next edge; next enabled Result is captured.
REQ-038 With RESULT_LOGGER_TS_EN, events at cycles 3 and 10 after reset -> out_ts values 3 and 10; counter wrap at 2^TS_WIDTH verified with TS_WIDTH = 4.
